mold_seq_ctrl: RTL and testbench
================================

# mold_seq_ctrl

MoldUDP64 sequence controller sitting beside the UDP payload datapath. Consumes the decoded downstream header (session, sequence number, message count) and per-message end strobes. Decides per message whether the datapath forwards or drops it, tracks the next expected sequence number, and raises one retransmission (gap) request toward the request-builder when packets are missing.

## Interface
- SID_W, 80, session field width in bits
- SEQ_W, 64, sequence number width
- ML_W, 16, message count / gap count width

Ports:
- clk  in  1  clock
- nreset  in  1  asynchronous active-low reset
- hdr_v_i  in  1  one-cycle pulse; header fields valid
- sid_i  in  SID_W  session id
- seq_num_i  in  SEQ_W  sequence number of first message in packet
- msg_cnt_i  in  ML_W  message count (0 = heartbeat, all-ones = end of session)
- msg_end_i  in  1  pulse; current message's last byte consumed
- pkt_end_i  in  1  pulse; AXI tlast beat of current packet
- msg_accept_o  out  1  level; current message is forwarded (0 = drop)
- expected_seq_o  out  SEQ_W  next expected sequence number
- sid_v_o  out  1  session locked
- sid_o  out  SID_W  locked session
- eos_o  out  1  end-of-session seen (sticky)
- gap_req_v_o  out  1  retransmit request valid
- gap_req_ready_i  in  1  request consumer ready
- gap_seq_o  out  SEQ_W  first missing sequence number
- gap_cnt_o  out  ML_W  number of missing messages
- sid_err_o  out  1  pulse; header with foreign session
- trunc_err_o  out  1  pulse; packet ended before msg_cnt messages

## Operation
- States: IDLE (unlocked), HDR (locked, awaiting header), MSG (streaming), EOS (terminal until reset).
- IDLE + hdr_v_i: lock sid_q=sid_i, expected_q=seq_num_i, classify as in-order.
- HDR + hdr_v_i, sid_i != sid_q: sid_err_o pulse, whole packet dropped, stay HDR.
- msg_cnt_i all-ones: eos_o=1, go EOS; further headers are ignored.
- msg_cnt_i=0 (heartbeat): if seq_num_i > expected_q raise gap; stay HDR.
- Classification, using sums computed in SEQ_W+1 bits:
  - seq+cnt <= expected is a duplicate: skip_q=cnt.
  - seq <= expected < seq+cnt is an overlap: skip_q=expected-seq.
  - seq == expected is in-order: skip_q=0.
  - seq > expected is a gap: raise gap, skip_q=cnt (drop all).
- Non-EOS, non-heartbeat header: rem_q=cnt, go MSG.
- MSG, on msg_end_i:
  - rem_q decrements.
  - if skip_q != 0, skip_q decrements; else expected_q increments (modulo 2^SEQ_W).
  - rem_q reaching 0 returns to HDR.
- msg_accept_o = (state==MSG) & (skip_q==0).
- Gap request:
  - Load gap_seq_o=expected_q and gap_cnt_o=min(seq-expected, 2^ML_W-1), then assert gap_req_v_o.
  - Hold fields until gap_req_v_o & gap_req_ready_i.
  - A new gap while one is pending is ignored; the pending request is not overwritten.
- pkt_end_i in MSG:
  - Go HDR.
  - If rem_q, after any simultaneous msg_end_i, is nonzero, pulse trunc_err_o.
  - Already accepted messages stay counted.
- hdr_v_i in MSG is ignored.

## Timing
- Reset (async assert, sync deassert externally): state IDLE; all outputs 0, expected_seq_o=0, sid_o=0.
- hdr_v_i at cycle N: state, msg_accept_o, skip_q, rem_q and gap_req_v_o valid at N+1.
- msg_end_i at N: msg_accept_o for the next message and expected_seq_o valid at N+1.
- sid_err_o and trunc_err_o: single-cycle pulses at N+1.
- Gap handshake is valid/ready: gap_req_v_o drops the cycle after acceptance and never deasserts without a handshake.
- If msg_end_i and pkt_end_i arrive together with rem_q==1, this is a clean end: no trunc_err_o.

## Structure
- Package mold_pkg holds:
  - SID_W, SEQ_W, ML_W
  - MSG_CNT_HB='0, MSG_CNT_EOS='1
  - state enum
  - classification enum {INORDER, OVERLAP, DUP, GAP}
- Sub-module mold_seq_cmp: combinational classifier taking seq, cnt and expected, producing class, skip count and saturated gap count.

## Test plan
- Unlocked, header sid=A seq=100 cnt=3, three msg_end_i: msg_accept_o=1 throughout; expected_seq_o=103; back to HDR.
- Locked at 103, header seq=101 cnt=4: first two messages have msg_accept_o=0, last two have 1; expected_seq_o=105.
- Locked at 105, header seq=110 cnt=2 with gap_req_ready_i=0 for 3 cycles: gap_seq_o=105 and gap_cnt_o=5 held until handshake; both messages dropped; expected stays 105.
- Header with sid=B while locked to A: sid_err_o pulse; no state change; expected unchanged.
- Header cnt=3 but pkt_end_i after one msg_end_i: trunc_err_o pulse; expected +1; next header accepted normally.
- Header cnt=0xFFFF: eos_o=1; later headers ignored. Assert nreset mid-MSG: outputs are 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/mold_pkg.sv
// Shared widths, special message-count codes and enums for the MoldUDP64
// sequence controller.
package mold_pkg;

    localparam int SID_W = 80;
    localparam int SEQ_W = 64;
    localparam int ML_W  = 16;

    localparam logic [ML_W-1:0] MSG_CNT_HB  = '0;
    localparam logic [ML_W-1:0] MSG_CNT_EOS = '1;

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        MSG,
        EOS
    } state_t;

    typedef enum logic [1:0] {
        INORDER,
        OVERLAP,
        DUP,
        GAP
    } cls_t;

endpackage

// File: rtl/mold_seq_cmp.sv
// Combinational header classifier: places a packet's sequence range relative
// to the next expected number and derives skip and saturated gap counts.
module mold_seq_cmp
    import mold_pkg::*;
(
    input  logic [SEQ_W-1:0] seq,
    input  logic [ML_W-1:0]  cnt,
    input  logic [SEQ_W-1:0] expected,
    output cls_t             cls,
    output logic [ML_W-1:0]  skip,
    output logic [ML_W-1:0]  gap_cnt
);

    function automatic logic [ML_W-1:0] sat_ml(input logic [SEQ_W-1:0] v);
        if (|v[SEQ_W-1:ML_W])
            return '1;
        else
            return v[ML_W-1:0];
    endfunction

    logic [SEQ_W:0]   seq_end;
    logic [SEQ_W-1:0] ahead;
    logic [ML_W-1:0]  behind;

    // One extra bit keeps seq+cnt from wrapping past the expected number.
    assign seq_end = {1'b0, seq} + {{(SEQ_W + 1 - ML_W){1'b0}}, cnt};
    assign ahead   = seq - expected;
    assign behind  = ML_W'(expected - seq);

    always_comb begin
        cls     = INORDER;
        skip    = '0;
        gap_cnt = '0;
        if (seq > expected) begin
            cls     = GAP;
            skip    = cnt;
            gap_cnt = sat_ml(ahead);
        end else if (seq_end <= {1'b0, expected}) begin
            cls  = DUP;
            skip = cnt;
        end else if (seq == expected) begin
            cls = INORDER;
        end else begin
            cls  = OVERLAP;
            skip = behind;
        end
    end

endmodule

// File: rtl/mold_seq_ctrl.sv
// MoldUDP64 sequence controller: session lock, per-message forward/drop,
// expected sequence tracking and a single outstanding gap request.
module mold_seq_ctrl
    import mold_pkg::*;
(
    input  logic             clk,
    input  logic             nreset,
    input  logic             hdr_v_i,
    input  logic [SID_W-1:0] sid_i,
    input  logic [SEQ_W-1:0] seq_num_i,
    input  logic [ML_W-1:0]  msg_cnt_i,
    input  logic             msg_end_i,
    input  logic             pkt_end_i,
    output logic             msg_accept_o,
    output logic [SEQ_W-1:0] expected_seq_o,
    output logic             sid_v_o,
    output logic [SID_W-1:0] sid_o,
    output logic             eos_o,
    output logic             gap_req_v_o,
    input  logic             gap_req_ready_i,
    output logic [SEQ_W-1:0] gap_seq_o,
    output logic [ML_W-1:0]  gap_cnt_o,
    output logic             sid_err_o,
    output logic             trunc_err_o
);

    state_t           state_q, state_d;
    logic [SID_W-1:0] sid_q, sid_d;
    logic             sid_v_q, sid_v_d;
    logic [SEQ_W-1:0] exp_q, exp_d;
    logic [ML_W-1:0]  rem_q, rem_d;
    logic [ML_W-1:0]  skip_q, skip_d;
    logic             eos_q, eos_d;
    logic             gap_v_q, gap_v_d;
    logic [SEQ_W-1:0] gap_seq_q, gap_seq_d;
    logic [ML_W-1:0]  gap_cnt_q, gap_cnt_d;
    logic             sid_err_q, sid_err_d;
    logic             trunc_err_q, trunc_err_d;

    cls_t             cls;
    logic [ML_W-1:0]  cmp_skip;
    logic [ML_W-1:0]  cmp_gap_cnt;
    logic [ML_W-1:0]  rem_dec;
    logic             gap_raise;

    mold_seq_cmp u_cmp (
        .seq      (seq_num_i),
        .cnt      (msg_cnt_i),
        .expected (exp_q),
        .cls      (cls),
        .skip     (cmp_skip),
        .gap_cnt  (cmp_gap_cnt)
    );

    assign rem_dec = msg_end_i ? (rem_q - ML_W'(1)) : rem_q;

    always_comb begin
        state_d     = state_q;
        sid_d       = sid_q;
        sid_v_d     = sid_v_q;
        exp_d       = exp_q;
        rem_d       = rem_q;
        skip_d      = skip_q;
        eos_d       = eos_q;
        gap_v_d     = gap_v_q;
        gap_seq_d   = gap_seq_q;
        gap_cnt_d   = gap_cnt_q;
        sid_err_d   = 1'b0;
        trunc_err_d = 1'b0;
        gap_raise   = 1'b0;

        if (gap_v_q && gap_req_ready_i)
            gap_v_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (hdr_v_i) begin
                    sid_d   = sid_i;
                    sid_v_d = 1'b1;
                    exp_d   = seq_num_i;
                    skip_d  = '0;
                    rem_d   = msg_cnt_i;
                    if (msg_cnt_i == MSG_CNT_EOS) begin
                        eos_d   = 1'b1;
                        state_d = EOS;
                    end else if (msg_cnt_i == MSG_CNT_HB) begin
                        state_d = HDR;
                    end else begin
                        state_d = MSG;
                    end
                end
            end
            HDR: begin
                if (hdr_v_i) begin
                    if (sid_i != sid_q) begin
                        sid_err_d = 1'b1;
                    end else if (msg_cnt_i == MSG_CNT_EOS) begin
                        eos_d   = 1'b1;
                        state_d = EOS;
                    end else if (msg_cnt_i == MSG_CNT_HB) begin
                        gap_raise = (cls == GAP);
                    end else begin
                        rem_d     = msg_cnt_i;
                        skip_d    = cmp_skip;
                        gap_raise = (cls == GAP);
                        state_d   = MSG;
                    end
                end
            end
            MSG: begin
                if (msg_end_i) begin
                    if (skip_q != '0)
                        skip_d = skip_q - ML_W'(1);
                    else
                        exp_d = exp_q + SEQ_W'(1);
                    if (rem_dec == '0)
                        state_d = HDR;
                end
                rem_d = rem_dec;
                // Messages already counted stay counted; only the remainder is flagged.
                if (pkt_end_i) begin
                    state_d     = HDR;
                    trunc_err_d = (rem_dec != '0);
                end
            end
            EOS: begin
            end
        endcase

        if (gap_raise && !gap_v_q) begin
            gap_v_d   = 1'b1;
            gap_seq_d = exp_q;
            gap_cnt_d = cmp_gap_cnt;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q     <= IDLE;
            sid_q       <= '0;
            sid_v_q     <= 1'b0;
            exp_q       <= '0;
            rem_q       <= '0;
            skip_q      <= '0;
            eos_q       <= 1'b0;
            gap_v_q     <= 1'b0;
            gap_seq_q   <= '0;
            gap_cnt_q   <= '0;
            sid_err_q   <= 1'b0;
            trunc_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sid_q       <= sid_d;
            sid_v_q     <= sid_v_d;
            exp_q       <= exp_d;
            rem_q       <= rem_d;
            skip_q      <= skip_d;
            eos_q       <= eos_d;
            gap_v_q     <= gap_v_d;
            gap_seq_q   <= gap_seq_d;
            gap_cnt_q   <= gap_cnt_d;
            sid_err_q   <= sid_err_d;
            trunc_err_q <= trunc_err_d;
        end
    end

    assign msg_accept_o   = (state_q == MSG) && (skip_q == '0);
    assign expected_seq_o = exp_q;
    assign sid_v_o        = sid_v_q;
    assign sid_o          = sid_q;
    assign eos_o          = eos_q;
    assign gap_req_v_o    = gap_v_q;
    assign gap_seq_o      = gap_seq_q;
    assign gap_cnt_o      = gap_cnt_q;
    assign sid_err_o      = sid_err_q;
    assign trunc_err_o    = trunc_err_q;

endmodule

// File: tb/tb_mold_seq_ctrl.sv
// Scoreboard bench for mold_seq_ctrl: a per-message reference model feeds
// expectation queues that an independent monitor drains.
module tb_mold_seq_ctrl;
    import mold_pkg::*;

    logic             clk = 1'b0;
    logic             nreset = 1'b1;
    logic             hdr_v_i = 1'b0;
    logic [SID_W-1:0] sid_i = '0;
    logic [SEQ_W-1:0] seq_num_i = '0;
    logic [ML_W-1:0]  msg_cnt_i = '0;
    logic             msg_end_i = 1'b0;
    logic             pkt_end_i = 1'b0;
    logic             msg_accept_o;
    logic [SEQ_W-1:0] expected_seq_o;
    logic             sid_v_o;
    logic [SID_W-1:0] sid_o;
    logic             eos_o;
    logic             gap_req_v_o;
    logic             gap_req_ready_i = 1'b0;
    logic [SEQ_W-1:0] gap_seq_o;
    logic [ML_W-1:0]  gap_cnt_o;
    logic             sid_err_o;
    logic             trunc_err_o;

    mold_seq_ctrl dut (
        .clk             (clk),
        .nreset          (nreset),
        .hdr_v_i         (hdr_v_i),
        .sid_i           (sid_i),
        .seq_num_i       (seq_num_i),
        .msg_cnt_i       (msg_cnt_i),
        .msg_end_i       (msg_end_i),
        .pkt_end_i       (pkt_end_i),
        .msg_accept_o    (msg_accept_o),
        .expected_seq_o  (expected_seq_o),
        .sid_v_o         (sid_v_o),
        .sid_o           (sid_o),
        .eos_o           (eos_o),
        .gap_req_v_o     (gap_req_v_o),
        .gap_req_ready_i (gap_req_ready_i),
        .gap_seq_o       (gap_seq_o),
        .gap_cnt_o       (gap_cnt_o),
        .sid_err_o       (sid_err_o),
        .trunc_err_o     (trunc_err_o)
    );

    always #5 clk = ~clk;

    localparam logic [SID_W-1:0] SID_A = 80'h00AA_1234_5678_9ABC_DEF0;
    localparam logic [SID_W-1:0] SID_B = 80'h00BB_0FED_CBA9_8765_4321;

    typedef struct {
        logic             acc;
        logic [SEQ_W-1:0] exp_after;
    } msg_ev_t;

    typedef struct {
        logic [SEQ_W-1:0] seq;
        logic [ML_W-1:0]  cnt;
    } gap_ev_t;

    msg_ev_t    acc_q[$];
    gap_ev_t    gap_q[$];
    logic [1:0] err_q[$];

    int pass_cnt = 0;
    int total_cnt = 0;

    // Reference model: session lock, next expected number, end-of-session.
    bit               m_locked = 1'b0;
    bit               m_eos = 1'b0;
    logic [SID_W-1:0] m_sid = '0;
    logic [SEQ_W-1:0] m_exp = '0;
    bit               hold_rdy = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        total_cnt++;
        if (act === req)
            pass_cnt++;
        else
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
    endtask

    task automatic fail(input string name);
        total_cnt++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send_hdr(input logic [SID_W-1:0] sid, input logic [SEQ_W-1:0] seq,
                            input logic [ML_W-1:0] cnt, output bit to_msg);
        logic [SEQ_W-1:0] ahead;
        gap_ev_t          g;
        to_msg = 1'b0;
        if (!m_eos) begin
            if (!m_locked) begin
                m_locked = 1'b1;
                m_sid    = sid;
                m_exp    = seq;
            end
            if (sid != m_sid) begin
                err_q.push_back(2'b01);
            end else if (cnt == 16'hFFFF) begin
                m_eos = 1'b1;
            end else begin
                if (seq > m_exp) begin
                    ahead = seq - m_exp;
                    g.seq = m_exp;
                    g.cnt = (ahead > 64'd65535) ? 16'hFFFF : ahead[15:0];
                    if (gap_q.size() == 0)
                        gap_q.push_back(g);
                end
                to_msg = (cnt != 0);
            end
        end
        hdr_v_i   = 1'b1;
        sid_i     = sid;
        seq_num_i = seq;
        msg_cnt_i = cnt;
        cyc();
        hdr_v_i = 1'b0;
    endtask

    // A message is forwarded exactly when its own number is the next expected one.
    task automatic send_msgs(input logic [SEQ_W-1:0] seq, input int cnt, input int n_ends, input bit pend);
        msg_ev_t ev;
        if (pend && n_ends < cnt)
            err_q.push_back(2'b10);
        for (int i = 0; i < n_ends; i++) begin
            ev.acc = ((seq + 64'(i)) == m_exp);
            if (ev.acc)
                m_exp = m_exp + 64'd1;
            ev.exp_after = m_exp;
            acc_q.push_back(ev);
            msg_end_i = 1'b1;
            pkt_end_i = pend && (i == n_ends - 1);
            cyc();
            msg_end_i = 1'b0;
            pkt_end_i = 1'b0;
            if ($urandom_range(0, 2) == 0)
                cyc();
        end
        if (pend && n_ends == 0) begin
            pkt_end_i = 1'b1;
            cyc();
            pkt_end_i = 1'b0;
        end
    endtask

    task automatic pkt(input logic [SID_W-1:0] sid, input logic [SEQ_W-1:0] seq,
                       input int cnt, input int n_ends, input bit pend);
        bit tm;
        send_hdr(sid, seq, 16'(cnt), tm);
        if (tm)
            send_msgs(seq, cnt, n_ends, pend);
    endtask

    task automatic drain();
        int n;
        n = 0;
        hold_rdy = 1'b0;
        while (gap_q.size() != 0 && n < 200) begin
            cyc();
            n++;
        end
        if (gap_q.size() != 0)
            fail("gap_drain_timeout");
        cyc();
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            gap_req_ready_i = hold_rdy ? 1'b0 : ($urandom_range(0, 2) != 0);
        end
    end

    // Monitor: pops expectations whenever the DUT presents a response.
    initial begin
        bit               pend_e;
        logic [SEQ_W-1:0] pend_exp;
        bit               pv;
        bit               phs;
        logic [SEQ_W-1:0] ps;
        logic [ML_W-1:0]  pc;
        msg_ev_t          ev;
        gap_ev_t          g;
        logic [1:0]       code;
        logic [1:0]       want;
        pend_e = 1'b0;
        pv     = 1'b0;
        phs    = 1'b0;
        forever begin
            @(negedge clk);
            if (!nreset) begin
                pend_e = 1'b0;
                pv     = 1'b0;
                continue;
            end
            if (pend_e) begin
                chk("expected_seq", expected_seq_o, pend_exp);
                pend_e = 1'b0;
            end
            if (pv && !phs) begin
                chk("gap_hold_v", gap_req_v_o, 1'b1);
                chk("gap_hold_seq", gap_seq_o, ps);
                chk("gap_hold_cnt", gap_cnt_o, pc);
            end
            if (msg_end_i) begin
                if (acc_q.size() == 0) begin
                    fail("msg_end_unexpected");
                end else begin
                    ev = acc_q.pop_front();
                    chk("msg_accept", msg_accept_o, ev.acc);
                    pend_exp = ev.exp_after;
                    pend_e   = 1'b1;
                end
            end
            if (gap_req_v_o && gap_req_ready_i) begin
                if (gap_q.size() == 0) begin
                    fail("gap_req_unexpected");
                end else begin
                    g = gap_q.pop_front();
                    chk("gap_seq", gap_seq_o, g.seq);
                    chk("gap_cnt", gap_cnt_o, g.cnt);
                end
            end
            if (sid_err_o || trunc_err_o) begin
                code = {trunc_err_o, sid_err_o};
                if (err_q.size() == 0) begin
                    $display("FAIL err_pulse_unexpected: got %b, required none at %0t", code, $time);
                    total_cnt++;
                end else begin
                    want = err_q.pop_front();
                    chk("err_pulse", code, want);
                end
            end
            pv  = gap_req_v_o;
            phs = gap_req_v_o && gap_req_ready_i;
            ps  = gap_seq_o;
            pc  = gap_cnt_o;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bit               tm;
        int               r;
        int               c;
        logic [SEQ_W-1:0] s;

        #2 nreset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_accept", msg_accept_o, 1'b0);
        chk("rst_expected", expected_seq_o, 64'd0);
        chk("rst_sid_v", sid_v_o, 1'b0);
        chk("rst_sid", sid_o, 80'd0);
        chk("rst_eos", eos_o, 1'b0);
        chk("rst_gap_v", gap_req_v_o, 1'b0);
        chk("rst_sid_err", sid_err_o, 1'b0);
        chk("rst_trunc_err", trunc_err_o, 1'b0);
        nreset = 1'b1;
        cyc();

        // Lock and in-order stream
        pkt(SID_A, 64'd100, 3, 3, 1'b0);
        cyc();
        chk("tp1_expected", expected_seq_o, 64'd103);
        chk("tp1_sid_v", sid_v_o, 1'b1);
        chk("tp1_sid", sid_o, SID_A);

        // Overlap: two duplicates then two new
        pkt(SID_A, 64'd101, 4, 4, 1'b0);

        // Gap with a stalled consumer
        drain();
        hold_rdy = 1'b1;
        cyc();
        send_hdr(SID_A, 64'd110, 16'd2, tm);
        send_msgs(64'd110, 2, 2, 1'b0);
        cyc();
        chk("tp3_gap_v", gap_req_v_o, 1'b1);
        chk("tp3_gap_seq", gap_seq_o, 64'd105);
        chk("tp3_gap_cnt", gap_cnt_o, 16'd5);
        chk("tp3_expected", expected_seq_o, 64'd105);
        drain();

        // Foreign session
        send_hdr(SID_B, 64'd105, 16'd2, tm);
        cyc();
        chk("tp4_expected", expected_seq_o, 64'd105);
        chk("tp4_sid", sid_o, SID_A);
        chk("tp4_accept", msg_accept_o, 1'b0);

        // Truncated packet, then a normal one
        pkt(SID_A, 64'd105, 3, 1, 1'b1);
        cyc();
        chk("tp5_expected", expected_seq_o, 64'd106);
        pkt(SID_A, 64'd106, 2, 2, 1'b0);

        // Gap count saturation and heartbeat gap
        drain();
        pkt(SID_A, m_exp + 64'd70000, 1, 1, 1'b0);
        drain();
        send_hdr(SID_A, m_exp + 64'd3, 16'd0, tm);
        drain();
        send_hdr(SID_A, m_exp, 16'd0, tm);

        for (int k = 0; k < 80; k++) begin
            r = $urandom_range(0, 99);
            c = $urandom_range(1, 5);
            s = m_exp + 64'($urandom_range(0, 14)) - 64'd6;
            if (r < 10)
                send_hdr(SID_B, s, 16'(c), tm);
            else if (r < 20)
                send_hdr(SID_A, s, 16'd0, tm);
            else if (r < 35)
                pkt(SID_A, s, c, $urandom_range(0, c - 1), 1'b1);
            else
                pkt(SID_A, s, c, c, 1'($urandom_range(0, 1)));
        end

        // End of session: later headers have no effect
        drain();
        send_hdr(SID_A, m_exp, 16'hFFFF, tm);
        cyc();
        chk("eos_set", eos_o, 1'b1);
        send_hdr(SID_A, m_exp + 64'd9, 16'd4, tm);
        send_hdr(SID_B, m_exp, 16'd2, tm);
        repeat (3) cyc();
        chk("eos_sticky", eos_o, 1'b1);
        chk("eos_no_gap", gap_req_v_o, 1'b0);
        chk("eos_expected", expected_seq_o, m_exp);
        chk("eos_accept", msg_accept_o, 1'b0);

        // Asynchronous reset in the middle of a packet
        nreset = 1'b0;
        cyc();
        m_locked = 1'b0;
        m_eos    = 1'b0;
        nreset   = 1'b1;
        cyc();
        send_hdr(SID_A, 64'd500, 16'd3, tm);
        send_msgs(64'd500, 3, 1, 1'b0);
        cyc();
        cyc();
        chk("pre_rst_accept", msg_accept_o, 1'b1);
        chk("pre_rst_expected", expected_seq_o, 64'd501);
        #2 nreset = 1'b0;
        #1;
        chk("arst_accept", msg_accept_o, 1'b0);
        chk("arst_expected", expected_seq_o, 64'd0);
        chk("arst_sid_v", sid_v_o, 1'b0);
        chk("arst_sid", sid_o, 80'd0);
        chk("arst_eos", eos_o, 1'b0);
        chk("arst_gap_v", gap_req_v_o, 1'b0);
        cyc();
        nreset = 1'b1;
        cyc();

        chk("acc_q_empty", acc_q.size(), 0);
        chk("gap_q_empty", gap_q.size(), 0);
        chk("err_q_empty", err_q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
